// File: rtl/axil_regfile32_pkg.sv
// Shared constants, types and the byte-strobe merge helper for the
// axil_regfile32 AXI4-Lite register block.
package axil_regfile32_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 7;
  localparam int NUM_REGS = 32;
  localparam int ADDR_LSB = 2;
  localparam int STRB_W   = DATA_W / 8;
  localparam int IDX_W    = ADDR_W - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [DATA_W-1:0] reg_array_t [NUM_REGS];

  // Merge new data into an old word, one byte lane per strobe bit.
  function automatic logic [DATA_W-1:0] apply_strb(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regfile32_if.sv
// AXI4-Lite bus bundle for axil_regfile32 (clock and reset stay plain ports).
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where both VALID and READY are high; once VALID is raised the sender
// holds it and its payload stable until that edge.
interface axil_regfile32_if;
  import axil_regfile32_pkg::*;

  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [DATA_W-1:0] S_AXI_WDATA;
  logic [STRB_W-1:0] S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/axil_regfile32_checker.sv
// Simulation protocol monitor for axil_regfile32. The module only exists when
// AXIL_REGFILE32_PROTOCOL_CHECK_EN is defined; it drives nothing.
`ifdef AXIL_REGFILE32_PROTOCOL_CHECK_EN
module axil_regfile32_checker
  import axil_regfile32_pkg::*;
(
  input logic              i_clk,
  input logic              i_rst_n,
  input logic              i_awvalid,
  input logic              i_awready,
  input logic              i_wvalid,
  input logic              i_wready,
  input logic              i_bvalid,
  input logic              i_bready,
  input logic [1:0]        i_bresp,
  input logic              i_arvalid,
  input logic              i_arready,
  input logic              i_rvalid,
  input logic              i_rready,
  input logic [1:0]        i_rresp,
  input logic [DATA_W-1:0] i_rdata
);

  logic              r_bvalid_q, r_bready_q, r_rvalid_q, r_rready_q;
  logic [DATA_W-1:0] r_rdata_q;
  logic              r_wpend, r_rpend;
  logic [3:0]        r_aw_cnt, r_ar_cnt, r_b_cnt, r_r_cnt;
  logic              w_wr_fire, w_rd_fire;

  assign w_wr_fire = i_awvalid & i_awready & i_wvalid & i_wready;
  assign w_rd_fire = i_arvalid & i_arready;

  // Previous-cycle history plus saturating stall/latency counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bvalid_q <= 1'b0;
      r_bready_q <= 1'b0;
      r_rvalid_q <= 1'b0;
      r_rready_q <= 1'b0;
      r_rdata_q  <= '0;
      r_wpend    <= 1'b0;
      r_rpend    <= 1'b0;
      r_aw_cnt   <= '0;
      r_ar_cnt   <= '0;
      r_b_cnt    <= '0;
      r_r_cnt    <= '0;
    end else begin
      r_bvalid_q <= i_bvalid;
      r_bready_q <= i_bready;
      r_rvalid_q <= i_rvalid;
      r_rready_q <= i_rready;
      r_rdata_q  <= i_rdata;
      r_wpend    <= w_wr_fire | (r_wpend & ~i_bvalid);
      r_rpend    <= w_rd_fire | (r_rpend & ~i_rvalid);
      r_aw_cnt   <= (i_awvalid & ~i_awready) ? r_aw_cnt + {3'b0, r_aw_cnt != 4'hF} : '0;
      r_ar_cnt   <= (i_arvalid & ~i_arready) ? r_ar_cnt + {3'b0, r_ar_cnt != 4'hF} : '0;
      r_b_cnt    <= (r_wpend & ~i_bvalid) ? r_b_cnt + {3'b0, r_b_cnt != 4'hF} : '0;
      r_r_cnt    <= (r_rpend & ~i_rvalid) ? r_r_cnt + {3'b0, r_r_cnt != 4'hF} : '0;
    end
  end

  // Rule checks, evaluated every clock outside reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(r_bvalid_q && !r_bready_q && !i_bvalid)) else $error("BVALID dropped without handshake");
      assert (!(r_rvalid_q && !r_rready_q && !i_rvalid)) else $error("RVALID dropped without handshake");
      assert (!(r_rvalid_q && !r_rready_q && i_rdata != r_rdata_q)) else $error("RDATA changed while stalled");
      assert (!(w_wr_fire && i_bvalid && !i_bready)) else $error("second outstanding write response");
      assert (!(w_rd_fire && i_rvalid && !i_rready)) else $error("second outstanding read response");
      assert (!(i_bvalid && i_bresp != RESP_OKAY)) else $error("BRESP not OKAY");
      assert (!(i_rvalid && i_rresp != RESP_OKAY)) else $error("RRESP not OKAY");
      assert (!(r_aw_cnt == 4'hF && i_awvalid && !i_awready)) else $error("AWREADY stall over 15 cycles");
      assert (!(r_ar_cnt == 4'hF && i_arvalid && !i_arready)) else $error("ARREADY stall over 15 cycles");
      assert (!(r_b_cnt == 4'hF && r_wpend && !i_bvalid)) else $error("write response delay over 15 cycles");
      assert (!(r_r_cnt == 4'hF && r_rpend && !i_rvalid)) else $error("read response delay over 15 cycles");
    end
  end

endmodule
`endif

// File: rtl/axil_regfile32.sv
// AXI4-Lite slave with 32 x 32-bit read/write registers. Write and read
// channels are independent; responses are always OKAY and held until taken.
// Optional build macro: AXIL_REGFILE32_PROTOCOL_CHECK_EN adds the protocol
// monitor (axil_regfile32_checker); the datapath is identical either way.
module axil_regfile32
  import axil_regfile32_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input logic               S_AXI_ACLK,
  input logic               S_AXI_ARESETN,
  axil_regfile32_if.slave   s_axi
);

  logic                          r_awready, r_wready, r_bvalid;
  logic                          r_arready, r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  reg_array_t                    r_regs;

  logic             w_wr_accept, w_wr_fire, w_rd_accept, w_rd_fire;
  logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
  logic             w_unused_ok;

  // Address and data are only ever taken together, and only when the
  // response slot is free or being drained this cycle.
  assign w_wr_accept = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~r_awready
                     & (~r_bvalid | s_axi.S_AXI_BREADY);
  assign w_wr_fire   = r_awready & r_wready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign w_rd_accept = s_axi.S_AXI_ARVALID & ~r_arready & (~r_rvalid | s_axi.S_AXI_RREADY);
  assign w_rd_fire   = r_arready & s_axi.S_AXI_ARVALID;
  assign w_wr_idx    = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign w_rd_idx    = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;

  // Protection bits and byte-offset address bits carry no meaning here.
  assign w_unused_ok = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write channel: one-cycle AW/W ready pulse, then BVALID held until BREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= w_wr_accept;
      r_wready  <= w_wr_accept;
      if (w_wr_fire)                  r_bvalid <= 1'b1;
      else if (s_axi.S_AXI_BREADY)    r_bvalid <= 1'b0;
    end
  end

  // Read channel: one-cycle AR ready pulse, data captured on the address
  // handshake (pre-write value on a same-cycle collision), held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= w_rd_accept;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_regs[w_rd_idx];
      end else if (s_axi.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Register file: byte-lane merge on the write handshake.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_fire) begin
      r_regs[w_wr_idx] <= apply_strb(r_regs[w_wr_idx], s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
    end
  end

`ifdef AXIL_REGFILE32_PROTOCOL_CHECK_EN
  axil_regfile32_checker u_checker (
    .i_clk     (S_AXI_ACLK),
    .i_rst_n   (S_AXI_ARESETN),
    .i_awvalid (s_axi.S_AXI_AWVALID),
    .i_awready (r_awready),
    .i_wvalid  (s_axi.S_AXI_WVALID),
    .i_wready  (r_wready),
    .i_bvalid  (r_bvalid),
    .i_bready  (s_axi.S_AXI_BREADY),
    .i_bresp   (RESP_OKAY),
    .i_arvalid (s_axi.S_AXI_ARVALID),
    .i_arready (r_arready),
    .i_rvalid  (r_rvalid),
    .i_rready  (s_axi.S_AXI_RREADY),
    .i_rresp   (RESP_OKAY),
    .i_rdata   (r_rdata)
  );
`else
`endif

endmodule

// File: tb/tb_axil_regfile32.sv
// Directed bench for axil_regfile32: reset, strobed writes, backpressure on
// both response channels, read/write collision and asynchronous reset.
module tb_axil_regfile32;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  logic [31:0] exp_q[$];

  axil_regfile32_if bus();

  axil_regfile32 dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus)
  );

  // Clock and global time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write with BREADY high; checks the handshake and OKAY response.
  task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.S_AXI_AWREADY && n < 20);
    chk("wr_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    chk("wr_wready", 32'(bus.S_AXI_WREADY), 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    chk("wr_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    chk("wr_bresp", 32'(bus.S_AXI_BRESP), 32'd0);
    tick();
    chk("wr_bvalid_clr", 32'(bus.S_AXI_BVALID), 32'd0);
  endtask

  // Full read with RREADY high; data compared against the scoreboard head.
  task automatic axi_read(input logic [6:0] addr);
    int n;
    logic [31:0] exp;
    exp = 32'hxxxxxxxx;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.S_AXI_ARREADY && n < 20);
    chk("rd_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    chk("rd_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    chk("rd_rresp", 32'(bus.S_AXI_RRESP), 32'd0);
    chk($sformatf("rd_data_%02h", addr), bus.S_AXI_RDATA, exp);
    tick();
    chk("rd_rvalid_clr", 32'(bus.S_AXI_RVALID), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd0);
    chk({tag, "_wready"},  32'(bus.S_AXI_WREADY),  32'd0);
    chk({tag, "_bvalid"},  32'(bus.S_AXI_BVALID),  32'd0);
    chk({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'd0);
    chk({tag, "_rvalid"},  32'(bus.S_AXI_RVALID),  32'd0);
    chk({tag, "_rdata"},   bus.S_AXI_RDATA,        32'd0);
    chk({tag, "_bresp"},   32'(bus.S_AXI_BRESP),   32'd0);
    chk({tag, "_rresp"},   32'(bus.S_AXI_RRESP),   32'd0);
  endtask

  initial begin
    int n;
    int aw_pulses;
    int w_pulses;
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;

    // Reset: outputs idle, every register zero.
    tick();
    chk_idle_outputs("rst");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(32'h0);
      axi_read(7'(i * 4));
    end

    // Partial write, top byte lane only; low address bits are ignored.
    axi_write(7'h40, 32'h8000_0000, 4'b1000);
    exp_q.push_back(32'h8000_0000);
    axi_read(7'h40);
    exp_q.push_back(32'h8000_0000);
    axi_read(7'h43);

    // Write response backpressure with AW/W held high throughout.
    bus.S_AXI_AWADDR  = 7'h40;
    bus.S_AXI_WDATA   = 32'h1234_5678;
    bus.S_AXI_WSTRB   = 4'b1111;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b0;
    aw_pulses = 0;
    w_pulses  = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.S_AXI_AWREADY) aw_pulses++;
      if (bus.S_AXI_WREADY)  w_pulses++;
    end
    chk("bp_aw_pulses", 32'(aw_pulses), 32'd1);
    chk("bp_w_pulses", 32'(w_pulses), 32'd1);
    chk("bp_bvalid_held", 32'(bus.S_AXI_BVALID), 32'd1);
    bus.S_AXI_WDATA  = 32'h0000_ABCD;
    bus.S_AXI_BREADY = 1'b1;
    tick();
    chk("bp_bvalid_clr", 32'(bus.S_AXI_BVALID), 32'd0);
    chk("bp_second_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    chk("bp_second_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    chk("bp_second_awready_clr", 32'(bus.S_AXI_AWREADY), 32'd0);
    tick();
    chk("bp_second_bvalid_clr", 32'(bus.S_AXI_BVALID), 32'd0);
    exp_q.push_back(32'h0000_ABCD);
    axi_read(7'h40);

    // Read backpressure and same-cycle read/write collision on reg16.
    axi_write(7'h40, 32'h0, 4'b1111);
    bus.S_AXI_AWADDR  = 7'h40;
    bus.S_AXI_WDATA   = 32'h8000_0000;
    bus.S_AXI_WSTRB   = 4'b1111;
    bus.S_AXI_ARADDR  = 7'h40;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_RREADY  = 1'b0;
    tick();
    chk("col_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    chk("col_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    chk("col_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    chk("col_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    chk("col_rdata_old", bus.S_AXI_RDATA, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("col_rvalid_held", 32'(bus.S_AXI_RVALID), 32'd1);
      chk("col_rdata_held", bus.S_AXI_RDATA, 32'h0);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    chk("col_rvalid_clr", 32'(bus.S_AXI_RVALID), 32'd0);
    exp_q.push_back(32'h8000_0000);
    axi_read(7'h40);

    // Byte strobes: mixed lanes, then an all-zero strobe that changes nothing.
    axi_write(7'h04, 32'hAABB_CCDD, 4'b1111);
    axi_write(7'h04, 32'h1122_3344, 4'b0101);
    exp_q.push_back(32'hAA22_CC44);
    axi_read(7'h04);
    axi_write(7'h04, 32'hFFFF_FFFF, 4'b0000);
    exp_q.push_back(32'hAA22_CC44);
    axi_read(7'h04);

    // Highest register.
    axi_write(7'h7C, 32'hDEAD_BEEF, 4'b1111);
    exp_q.push_back(32'hDEAD_BEEF);
    axi_read(7'h7C);
    exp_q.push_back(32'h0);
    axi_read(7'h78);

    // Asynchronous reset while a write response is pending.
    bus.S_AXI_AWADDR  = 7'h08;
    bus.S_AXI_WDATA   = 32'h0000_0005;
    bus.S_AXI_WSTRB   = 4'b1111;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.S_AXI_AWREADY && n < 20);
    chk("mr_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    chk("mr_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mr");
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(32'h0);
    axi_read(7'h08);
    exp_q.push_back(32'h0);
    axi_read(7'h04);
    exp_q.push_back(32'h0);
    axi_read(7'h40);
    exp_q.push_back(32'h0);
    axi_read(7'h7C);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axil_regfile32.md
Name: axil_regfile32

Overview:
- AXI4-Lite slave exposing 32 read/write 32-bit registers (slv_reg0..slv_reg31) on a 7-bit byte address space.
- Used as a generic control/status register block behind an AXI-Lite interconnect.
- Write and read channels run independently.
- Responses are always OKAY and are held until the master accepts them.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 7, byte address width: bits [6:2] select the register, bits [1:0] are ignored.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR  in  7  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address accepted.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte lane enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data accepted.
- S_AXI_BRESP  out  2  write response; always 2'b00.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  master accepts write response.
- S_AXI_ARADDR  in  7  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address accepted.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  master accepts read data.

Behaviour:
- Reset: while S_AXI_ARESETN=0, asynchronously clear all outputs (AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA) and all 32 registers to 0. This applies mid-transaction; in-flight transactions are dropped.
- Write accept:
  - Condition: AWVALID & WVALID & !AWREADY & (!BVALID | BREADY).
  - Effect: AWREADY and WREADY both pulse high for exactly one cycle.
  - The slave never accepts address without data, or data without address.
- Register write: in the cycle AWREADY&WREADY&AWVALID&WVALID, write slv_reg[AWADDR[6:2]].
  - Byte lane i updates from WDATA[8i+7:8i] only if WSTRB[i]=1; other lanes keep their value.
  - WSTRB=0 writes nothing but still completes with OKAY.
- Write response:
  - BVALID rises on the cycle after the accept and holds until BVALID&BREADY, then clears.
  - No new write is accepted while BVALID=1 and BREADY=0.
  - Back-to-back throughput is 1 write per 2 cycles.
- Read accept:
  - Condition: ARVALID & !ARREADY & (!RVALID | RREADY).
  - Effect: ARREADY pulses for one cycle.
- Read data:
  - On the accept cycle, capture RDATA <= slv_reg[ARADDR[6:2]] (value before any same-cycle write).
  - RVALID rises next cycle. RDATA and RVALID hold stable until RVALID&RREADY, then RVALID clears.
- Read/write collision: a read and a write to the same register accepted in the same cycle return the old value.
- Address decoding: every address in 0x00..0x7C is valid; there is no error response.
- AWPROT/ARPROT are unused.
- Latency: write response 1 cycle after accept; read data 1 cycle after accept.

Optional Feature:
- Macro: AXIL_REGFILE32_PROTOCOL_CHECK_EN.
- When defined, instantiate the protocol checker, which flags a simulation error on any of:
  - BVALID or RVALID dropping without a handshake;
  - RDATA changing while RVALID=1 and RREADY=0;
  - more than one outstanding write or read response;
  - BRESP or RRESP non-zero;
  - AWREADY/ARREADY stall or response delay exceeding 15 cycles (4-bit counters, reset to 0).
- When undefined, no checker logic exists and the datapath is unchanged.

Decomposition:
- Package axil_regfile32_pkg:
  - DATA_W=32, ADDR_W=7, NUM_REGS=32, ADDR_LSB=2;
  - RESP_OKAY=2'b00;
  - typedef for the register array.
- One sub-module, axil_regfile32_checker, holds the optional protocol checks. The top level holds the handshakes and the register file.

Test Plan:
- Reset: hold ARESETN=0 for 1 cycle -> all ready/valid outputs 0, RDATA=0, every register reads 0x00000000.
- Partial write/readback: write AWADDR=0x40, WDATA=0x80000000, WSTRB=4'b1000, BREADY=1 -> BVALID for one cycle with BRESP=0; read 0x40 -> RDATA=0x80000000, RRESP=0.
- Response backpressure: write 0x40 with BREADY=0 while AWVALID/WVALID stay high for 4 cycles -> exactly one AWREADY/WREADY pulse, BVALID stays 1; raise BREADY -> BVALID clears the next cycle, then a second write is accepted.
- Read backpressure and collision: simultaneous AR/AW/W to 0x40 (write data 0x80000000), reg16=0, RREADY=0 for 3 cycles -> RVALID held with RDATA=0 (old value); after RREADY, a new read returns 0x80000000.
- Byte strobes: write 0xAABBCCDD to 0x04 with WSTRB=1111, then 0x11223344 with WSTRB=0101 -> readback 0xAA22CC44.
- Reset mid-write: drop ARESETN while BVALID=1 -> BVALID=0 immediately (asynchronous), and registers are cleared to 0.
